mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the single-cycle core's data-store bus, alongside the data memory. It decodes stores to a small register window, queues bytes in a FIFO, and serialises them as 8N1 frames on `tx`. It also drives a status word that the top-level read mux returns to the core in place of data-memory `ReadData` when the window is addressed.

---
 rtl/mmio_uart_tx_if.sv | 26 ++
 rtl/mmio_uart_tx.sv | 234 +++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// Core data-store bus slice seen by the memory-mapped UART transmitter.
// The core drives the store strobe, address and data; the UART returns the
// window-select flag and the status read word for the top-level read mux.
interface mmio_uart_tx_if;
  logic        MemWrite;
  logic [31:0] DataAddr;
  logic [31:0] WriteData;
  logic        rd_sel;
  logic [31:0] RdData;

  modport master (
    output MemWrite,
    output DataAddr,
    output WriteData,
    input  rd_sel,
    input  RdData
  );

  modport slave (
    input  MemWrite,
    input  DataAddr,
    input  WriteData,
    output rd_sel,
    output RdData
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter.
// Window: BASE_ADDR+0 TXDATA (write pushes a byte), BASE_ADDR+4 STATUS
// (read: full/empty/busy/ovf/count; write bit3=1 clears ovf).
// Bytes are queued in a circular FIFO and sent as 8N1 frames on tx.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (STATUS bit13 then reads 1).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [29:0]   TXDATA_WA = BASE_ADDR[31:2];
  localparam logic [29:0]   STATUS_WA = BASE_ADDR[31:2] + 30'd1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic PARITY_EN = 1'b1;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam logic PARITY_EN = 1'b0;
`endif

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_d;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];

  logic          hit_txdata;
  logic          hit_status;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          baud_last;
  logic [7:0]    head;
  logic [31:0]   status;
  logic          unused_bits;

  // Address decode works on word addresses; byte-lane bits are ignored.
  assign hit_txdata  = (bus.DataAddr[31:2] == TXDATA_WA);
  assign hit_status  = (bus.DataAddr[31:2] == STATUS_WA);
  assign bus.rd_sel  = (bus.DataAddr[31:3] == BASE_ADDR[31:3]);
  assign unused_bits = ^{bus.DataAddr[1:0], bus.WriteData[31:8]};

  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign push_req  = bus.MemWrite & hit_txdata;
  assign push      = push_req & ~full;
  assign head      = mem_q[rd_ptr_q];
  assign baud_last = (baud_q == BAUD_LAST);
  assign tx        = tx_q;

  // Status word assembled from pre-edge register state.
  always_comb begin
    status        = '0;
    status[0]     = full;
    status[1]     = empty;
    status[2]     = (state_q != IDLE);
    status[3]     = ovf_q;
    status[12:4]  = 9'(count_q);
    status[13]    = PARITY_EN;
    bus.RdData    = hit_status ? status : '0;
  end

  // Serialiser next-state: frame sequencing, baud timing and FIFO pop.
  // tx_d is the line level for the state being entered, so tx is registered
  // and changes exactly on the state/bit edge.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the byte captured with each pop.
  always_comb begin
    parity_d = parity_q;
    if (pop) begin
      parity_d = ^head;
    end
  end
`endif

  // FIFO pointers, occupancy and sticky overflow flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    ovf_d    = ovf_q;
    if (push_req && full) begin
      ovf_d = 1'b1;
    end else if (bus.MemWrite && hit_status && bus.WriteData[3]) begin
      ovf_d = 1'b0;
    end
  end

  // All control state registers, synchronous reset aborts any frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= bus.WriteData[7:0];
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam logic [31:0] STAT  = 32'h0000_0404;
`ifdef UART_TX_PARITY_EN
  localparam int          FRAME_BITS = 11;
  localparam logic        PAR        = 1'b1;
`else
  localparam int          FRAME_BITS = 10;
  localparam logic        PAR        = 1'b0;
`endif
  localparam int          FRAME_CYC = FRAME_BITS * CPB;
  localparam logic [31:0] PARBIT    = {18'h0, PAR, 13'h0};

  logic clk = 1'b0;
  logic reset;
  logic tx;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .tx   (tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Queue of accepted bytes; a frame is a bit vector walked by elapsed time.
  logic [7:0]  mq[$];
  bit          m_active;
  int          m_t;
  logic [10:0] m_bits;
  bit          m_ovf;

  function automatic logic [10:0] make_frame(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
    if (PAR) f[9] = ^b;
    return f;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (mq.size() == DEPTH);
    s[1]     = (mq.size() == 0);
    s[2]     = m_active;
    s[3]     = m_ovf;
    s[12:4]  = 9'(mq.size());
    s[13]    = PAR;
    return s;
  endfunction

  always @(posedge clk) begin
    int   sz_pre;
    logic [7:0] b;
    if (reset) begin
      mq.delete();
      m_active = 1'b0;
      m_t      = 0;
      m_ovf    = 1'b0;
    end else begin
      sz_pre = mq.size();
      if (m_active) begin
        m_t++;
        if (m_t == FRAME_CYC) m_active = 1'b0;
      end
      if (!m_active && sz_pre > 0) begin
        b        = mq.pop_front();
        m_bits   = make_frame(b);
        m_active = 1'b1;
        m_t      = 0;
      end
      if (bus.MemWrite && bus.DataAddr[31:2] == BASE[31:2]) begin
        if (sz_pre == DEPTH) m_ovf = 1'b1;
        else mq.push_back(bus.WriteData[7:0]);
      end
      if (bus.MemWrite && bus.DataAddr[31:2] == STAT[31:2] && bus.WriteData[3])
        m_ovf = 1'b0;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic exp_tx;
    if (chk_en) begin
      exp_tx = m_active ? m_bits[m_t / CPB] : 1'b1;
      check("model_tx", {31'h0, tx}, {31'h0, exp_tx});
      check("model_rd_sel", {31'h0, bus.rd_sel},
            {31'h0, (bus.DataAddr[31:3] == BASE[31:3])});
      check("model_rddata", bus.RdData,
            (bus.DataAddr[31:2] == STAT[31:2]) ? model_status() : 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.MemWrite  = 1'b1;
    bus.DataAddr  = a;
    bus.WriteData = d;
    tick();
    bus.MemWrite  = 1'b0;
    bus.DataAddr  = STAT;
    bus.WriteData = 32'h0;
  endtask

  task automatic check_frame(input logic [7:0] b, input logic [10:0] exp_bits, input string nm);
    store(BASE, {24'hABCDEF, b});
    @(negedge clk);
    check({nm, "_before_start"}, {31'h0, tx}, 32'h1);
    @(posedge clk);
    for (int i = 0; i < FRAME_CYC; i++) begin
      @(negedge clk);
      check($sformatf("%s_cycle%0d", nm, i), {31'h0, tx}, {31'h0, exp_bits[i / CPB]});
    end
    @(negedge clk);
    check({nm, "_after_tx"}, {31'h0, tx}, 32'h1);
    check({nm, "_after_status"}, bus.RdData, 32'h2 | PARBIT);
    tick();
  endtask

  initial begin
    int busy_n;
    int low_n;
    reset         = 1'b1;
    bus.MemWrite  = 1'b0;
    bus.DataAddr  = 32'h0;
    bus.WriteData = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    // Reset idle
    @(negedge clk);
    check("reset_tx", {31'h0, tx}, 32'h1);
    check("reset_rd_sel_addr0", {31'h0, bus.rd_sel}, 32'h0);
    check("reset_rddata_addr0", bus.RdData, 32'h0);
    tick();
    bus.DataAddr = STAT;
    @(negedge clk);
    check("reset_status", bus.RdData, 32'h2 | PARBIT);
    check("reset_rd_sel", {31'h0, bus.rd_sel}, 32'h1);
    tick();
    bus.DataAddr = BASE;
    @(negedge clk);
    check("txdata_read_zero", bus.RdData, 32'h0);
    tick();
    bus.DataAddr = STAT;

    // Single-byte frames with hand-computed bit patterns
`ifdef UART_TX_PARITY_EN
    check_frame(8'h07, 11'b11000001110, "par07");
    check_frame(8'h03, 11'b10000000110, "par03");
`else
    check_frame(8'hA5, 11'b11101001010, "frameA5");
`endif

    // Stores outside the window do nothing
    store(32'h0000_0408, 32'h55);
    store(32'h0000_03FC, 32'h55);
    @(negedge clk);
    check("outside_store_status", bus.RdData, 32'h2 | PARBIT);
    tick();

    // Burst of 10: one in the shifter, 8 queued, 10th dropped
    for (int i = 0; i < 10; i++) begin
      bus.MemWrite  = 1'b1;
      bus.DataAddr  = (i == 3) ? 32'h0000_0402 : BASE;
      bus.WriteData = 32'hFFFF_FF00 | 32'(8'h13 * i + 8'h21);
      tick();
    end
    bus.MemWrite  = 1'b0;
    bus.DataAddr  = STAT;
    bus.WriteData = 32'h0;
    @(negedge clk);
    check("burst_status_full_ovf", bus.RdData, 32'h8D | PARBIT);
    busy_n = 0;
    while (bus.RdData[2] === 1'b1 && busy_n < 2000) begin
      busy_n++;
      @(negedge clk);
    end
    check("burst_busy_cycles", busy_n, 9 * FRAME_CYC - 8);
    check("burst_end_status", bus.RdData, 32'hA | PARBIT);
    tick();

    // Overflow clear
    store(STAT, 32'h0);
    @(negedge clk);
    check("ovf_kept_on_zero", bus.RdData, 32'hA | PARBIT);
    tick();
    store(32'h0000_0406, 32'h8);
    @(negedge clk);
    check("ovf_cleared", bus.RdData, 32'h2 | PARBIT);
    tick();
    store(STAT, 32'hFFFF_FFF7);
    @(negedge clk);
    check("ovf_stays_clear", bus.RdData, 32'h2 | PARBIT);
    tick();

    // Reset mid-frame during data bit 3 (byte 0xF7 has bit 3 = 0)
    store(BASE, 32'hF7);
    store(BASE, 32'h11);
    store(BASE, 32'h22);
    store(BASE, 32'h33);
    repeat (15) @(posedge clk);
    #1;
    @(negedge clk);
    check("midframe_bit3_low", {31'h0, tx}, 32'h0);
    check("midframe_status", bus.RdData, 32'h34 | PARBIT);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("reset_abort_tx", {31'h0, tx}, 32'h1);
    check("reset_abort_status", bus.RdData, 32'h2 | PARBIT);
    low_n = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx !== 1'b1) low_n++;
    end
    check("reset_no_more_frames", low_n, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
